// File: rtl/hex_word_emitter.sv
// Serialises a WIDTH-bit word into lowercase ASCII hex characters (MSB nibble first) plus a separator.
// Optional macro HEX_EMIT_CRLF_EN appends CR and LF after the separator.

module bin2AsciiHex (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);
  always_comb begin
    if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
    else                ascii = 8'h57 + {4'h0, nibble};
  end
endmodule

module hex_word_emitter #(
  parameter int         WIDTH    = 16,
  parameter logic [7:0] SEP_CHAR = 8'h20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             busy
);
  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

`ifdef HEX_EMIT_CRLF_EN
  typedef enum logic [2:0] {ST_IDLE, ST_HEX, ST_SEP, ST_CR, ST_LF} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_HEX, ST_SEP} state_t;
`endif

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        hex_ascii;

  bin2AsciiHex u_conv (
    .nibble (sh_q[WIDTH-1:WIDTH-4]),
    .ascii  (hex_ascii)
  );

  // Every non-idle state presents a character, so handshake reduces to out_ready.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sh_d    = in_data;
          cnt_d   = '0;
          state_d = ST_HEX;
        end
      end
      ST_HEX: begin
        if (out_ready) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_SEP;
          end else begin
            sh_d  = sh_q << 4;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_SEP: begin
`ifdef HEX_EMIT_CRLF_EN
        if (out_ready) state_d = ST_CR;
`else
        if (out_ready) state_d = ST_IDLE;
`endif
      end
`ifdef HEX_EMIT_CRLF_EN
      ST_CR: if (out_ready) state_d = ST_LF;
      ST_LF: if (out_ready) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q != ST_IDLE);
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_HEX:  out_char = hex_ascii;
      ST_SEP:  out_char = SEP_CHAR;
`ifdef HEX_EMIT_CRLF_EN
      ST_CR:   out_char = 8'h0D;
      ST_LF:   out_char = 8'h0A;
`endif
      default: out_char = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_hex_word_emitter.sv
// Randomised and directed bench for hex_word_emitter against a per-character index model.
module tb_hex_word_emitter;
`ifdef HEX_EMIT_CRLF_EN
  localparam int EXTRA = 3;
`else
  localparam int EXTRA = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
  logic [15:0] in_data = '0;
  logic [7:0]  out_char;

  logic        v4 = 1'b0, r4, ov4, b4;
  logic [3:0]  d4 = '0;
  logic [7:0]  c4;
  logic        v32 = 1'b0, r32, ov32, b32;
  logic [31:0] d32 = '0;
  logic [7:0]  c32;
  logic        rdy_one = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  hex_word_emitter #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char), .busy(busy));

  hex_word_emitter #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .in_data(d4),
    .out_valid(ov4), .out_ready(rdy_one), .out_char(c4), .busy(b4));

  hex_word_emitter #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32), .in_data(d32),
    .out_valid(ov32), .out_ready(rdy_one), .out_char(c32), .busy(b32));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Character idx of the emitted stream for an n-nibble word.
  function automatic logic [7:0] exp_char(input logic [31:0] v, input int n, input int idx);
    int nib;
    if (idx < n) begin
      nib = int'((v >> (4 * (n - 1 - idx))) & 32'hF);
      return (nib < 10) ? 8'(48 + nib) : 8'(97 + nib - 10);
    end
    if (idx == n)     return 8'h20;
    if (idx == n + 1) return 8'h0D;
    return 8'h0A;
  endfunction

  // mode 0: out_ready always high, 1: fixed 1,0,0,1,0,1,1,1 pattern, 2: random
  task automatic run_word(input logic [15:0] data, input int mode, input bit junk);
    logic [7:0] pat;
    int idx, cyc, total;
    pat   = 8'b1110_1001;
    total = 4 + EXTRA;
    @(negedge clk);
    chk("idle_in_ready", {31'b0, in_ready}, 32'd1);
    chk("idle_out_valid", {31'b0, out_valid}, 32'd0);
    in_valid = 1'b1;
    in_data  = data;
    @(posedge clk); #1;
    in_valid = junk;
    in_data  = ~data;
    idx = 0;
    cyc = 0;
    while (idx < total && cyc < 200) begin
      @(negedge clk);
      chk("out_valid", {31'b0, out_valid}, 32'd1);
      chk("out_char", {24'b0, out_char}, {24'b0, exp_char({16'b0, data}, 4, idx)});
      chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc < 8) ? pat[cyc] : 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (out_ready) idx++;
      cyc++;
    end
    chk("cycle_budget", {31'b0, cyc < 200}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("done_busy", {31'b0, busy}, 32'd0);
    chk("done_in_ready", {31'b0, in_ready}, 32'd1);
    chk("done_out_valid", {31'b0, out_valid}, 32'd0);
    chk("done_out_char", {24'b0, out_char}, 32'd0);
    out_ready = $urandom_range(0, 1) != 0;
  endtask

  initial begin
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_char", {24'b0, out_char}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    run_word(16'h3A9F, 0, 1'b0);
    run_word(16'h0000, 0, 1'b0);
    run_word(16'hFFFF, 0, 1'b0);
    run_word(16'hBCDE, 0, 1'b0);
    run_word(16'h1234, 1, 1'b1);
    run_word(16'h00FF, 0, 1'b0);

    // Abandon a word mid-stream with an asynchronous reset.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'hABCD;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_c0", {24'b0, out_char}, 32'h61);
    @(negedge clk);
    chk("mid_c1", {24'b0, out_char}, 32'h62);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_char", {24'b0, out_char}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
    run_word(16'h0001, 0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      run_word(16'($urandom), 2, 1'($urandom_range(0, 1)));
    end

    // WIDTH=4 instance
    @(negedge clk);
    v4 = 1'b1;
    d4 = 4'h7;
    @(posedge clk); #1;
    v4 = 1'b0;
    for (int i = 0; i < 1 + EXTRA; i++) begin
      @(negedge clk);
      chk("w4_valid", {31'b0, ov4}, 32'd1);
      chk("w4_char", {24'b0, c4}, {24'b0, exp_char(32'h7, 1, i)});
    end
    @(negedge clk);
    chk("w4_idle", {31'b0, b4}, 32'd0);

    // WIDTH=32 instance
    @(negedge clk);
    v32 = 1'b1;
    d32 = 32'hDEADBEEF;
    @(posedge clk); #1;
    v32 = 1'b0;
    for (int i = 0; i < 8 + EXTRA; i++) begin
      @(negedge clk);
      chk("w32_valid", {31'b0, ov32}, 32'd1);
      chk("w32_char", {24'b0, c32}, {24'b0, exp_char(32'hDEADBEEF, 8, i)});
    end
    @(negedge clk);
    chk("w32_idle", {31'b0, b32}, 32'd0);
    chk("w32_ready", {31'b0, r32}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
